// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: one outstanding instruction-bus request, a one-entry output buffer,
// and branch/delay-slot/flush redirection of the fetch PC.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter bit          EXC_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  input  logic        br_is_jmp,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        br_stall
);

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {F_REQ, F_WAIT, F_HOLD, F_STALL} fetch_state_t;
  typedef enum logic [1:0] {B_NORMAL, B_DSLOT, B_WAIT_RES} br_state_t;

  fetch_state_t fetch_q, fetch_n;
  br_state_t    br_q, br_n;
  logic [31:0]  pc_q, pc_n;
  logic         drop_q, drop_n;
  logic         out_valid_q, out_valid_n;
  logic [31:0]  out_pc_q, out_pc_n;
  logic [31:0]  out_instr_q, out_instr_n;
  logic         res_pend_q, res_pend_n;
  logic         res_taken_q, res_taken_n;
  logic [31:0]  res_target_q, res_target_n;

  // A resolution arriving in the same cycle it is needed is used directly.
  logic        res_apply;
  logic        eff_taken;
  logic [31:0] eff_target;

  assign res_apply  = (br_q == B_WAIT_RES) && (res_valid || res_pend_q);
  assign eff_taken  = res_valid ? res_taken : res_taken_q;
  assign eff_target = res_valid ? res_target : res_target_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q      <= F_REQ;
      br_q         <= B_NORMAL;
      pc_q         <= RESET_PC & ALIGN;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
      res_pend_q   <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
    end else begin
      fetch_q      <= fetch_n;
      br_q         <= br_n;
      pc_q         <= pc_n;
      drop_q       <= drop_n;
      out_valid_q  <= out_valid_n;
      out_pc_q     <= out_pc_n;
      out_instr_q  <= out_instr_n;
      res_pend_q   <= res_pend_n;
      res_taken_q  <= res_taken_n;
      res_target_q <= res_target_n;
    end
  end

  always_comb begin
    fetch_n      = fetch_q;
    br_n         = br_q;
    pc_n         = pc_q;
    drop_n       = drop_q;
    out_valid_n  = out_valid_q;
    out_pc_n     = out_pc_q;
    out_instr_n  = out_instr_q;
    res_pend_n   = res_pend_q;
    res_taken_n  = res_taken_q;
    res_target_n = res_target_q;

    if (res_valid) begin
      res_pend_n   = 1'b1;
      res_taken_n  = res_taken;
      res_target_n = res_target;
    end

    if (flush) begin
      pc_n         = flush_pc & ALIGN;
      out_valid_n  = 1'b0;
      br_n         = B_NORMAL;
      res_pend_n   = 1'b0;
      res_taken_n  = 1'b0;
      res_target_n = '0;
      // A request already on the bus must have its response swallowed.
      if (fetch_q == F_REQ && ireq_addr_ok) begin
        fetch_n = F_WAIT;
        drop_n  = EXC_HOLD;
      end else if (fetch_q == F_WAIT && !iresp_data_ok) begin
        fetch_n = F_WAIT;
        drop_n  = EXC_HOLD;
      end else begin
        fetch_n = F_REQ;
        drop_n  = 1'b0;
      end
    end else begin
      case (fetch_q)
        F_REQ: begin
          if (ireq_addr_ok) fetch_n = F_WAIT;
        end
        F_WAIT: begin
          if (iresp_data_ok) begin
            if (drop_q) begin
              drop_n  = 1'b0;
              fetch_n = F_REQ;
            end else begin
              out_valid_n = 1'b1;
              out_pc_n    = pc_q;
              out_instr_n = iresp_data;
              fetch_n     = F_HOLD;
            end
          end
        end
        F_HOLD: begin
          if (out_ready) begin
            out_valid_n = 1'b0;
            pc_n        = (out_pc_q + 32'd4) & ALIGN;
            fetch_n     = F_REQ;
            if (br_q == B_DSLOT) begin
              br_n    = B_WAIT_RES;
              fetch_n = F_STALL;
            end else if (br_is_jmp) begin
              br_n = B_DSLOT;
            end
          end
        end
        F_STALL: begin
          // pc already holds delay-slot pc + 4, the not-taken continuation.
          if (res_apply) begin
            if (eff_taken) pc_n = eff_target & ALIGN;
            br_n       = B_NORMAL;
            fetch_n    = F_REQ;
            res_pend_n = 1'b0;
          end
        end
        default: fetch_n = F_REQ;
      endcase
    end
  end

  assign ireq_valid = (fetch_q == F_REQ) && !reset;
  assign ireq_addr  = pc_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;
  assign br_stall   = (br_q == B_WAIT_RES);

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: a bus responder plus a queue of expected {pc, instr} deliveries.
module tb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic        br_is_jmp = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        br_stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  fetch_pc_gen #(.RESET_PC(RESET_PC), .EXC_HOLD(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .br_is_jmp(br_is_jmp), .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush), .flush_pc(flush_pc), .br_stall(br_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2402_0001;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a request, accepts it after a_lat cycles, returns data d_lat cycles later.
  task automatic bus_fetch(input int a_lat, input int d_lat, output logic [31:0] addr,
                           output bit to, output bit moved);
    int n;
    to = 1'b0; moved = 1'b0; addr = '0; n = 0;
    while (ireq_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (ireq_valid !== 1'b1) begin
      to = 1'b1;
      return;
    end
    addr = ireq_addr;
    repeat (a_lat) begin
      tick();
      if (ireq_valid !== 1'b1 || ireq_addr !== addr) moved = 1'b1;
    end
    ireq_addr_ok = 1'b1;
    tick();
    ireq_addr_ok = 1'b0;
    repeat (d_lat) tick();
    iresp_data_ok = 1'b1;
    iresp_data = mem(addr);
    tick();
    iresp_data_ok = 1'b0;
    iresp_data = '0;
  endtask

  task automatic consume(input bit br, output logic [31:0] pc, output logic [31:0] instr,
                         output bit to);
    int n;
    to = 1'b0; n = 0; pc = '0; instr = '0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) begin
      to = 1'b1;
      return;
    end
    pc = out_pc;
    instr = out_instr;
    out_ready = 1'b1;
    br_is_jmp = br;
    tick();
    out_ready = 1'b0;
    br_is_jmp = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (ireq_valid !== 1'b0) begin errors++; $display("FAIL reset_ireq_valid: got %b want 0", ireq_valid); end
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++; $display("FAIL reset_out: got v=%b pc=%h instr=%h want 0/0/0", out_valid, out_pc, out_instr);
    end
    checks++;
    if (br_stall !== 1'b0) begin errors++; $display("FAIL reset_br_stall: got %b want 0", br_stall); end
    reset = 1'b0;
    tick();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req: got v=%b addr=%h want 1/%h", ireq_valid, ireq_addr, RESET_PC);
    end
  endtask

  task automatic test_first_fetch();
    logic [63:0] e;
    exp_q.push_back({RESET_PC, 32'h2402_0001});
    ireq_addr_ok = 1'b1;
    tick();
    ireq_addr_ok = 1'b0;
    checks++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL wait_cycle: got req=%b out_valid=%b want 0/0", ireq_valid, out_valid);
    end
    iresp_data_ok = 1'b1;
    iresp_data = mem(RESET_PC);
    tick();
    iresp_data_ok = 1'b0;
    checks++;
    e = exp_q.pop_front();
    if (out_valid !== 1'b1 || {out_pc, out_instr} !== e) begin
      errors++; $display("FAIL first_out: got v=%b %h/%h want 1 %h/%h", out_valid, out_pc, out_instr, e[63:32], e[31:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0004) begin
      errors++; $display("FAIL next_seq_addr: got v=%b addr=%h want 1/bfc00004", ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] ea, a, pc, ins;
    logic [63:0] e;
    bit to, mv, cto;
    for (int i = 0; i < 3; i++) begin
      ea = 32'hBFC0_0004 + 32'(i * 4);
      exp_q.push_back({ea, mem(ea)});
      bus_fetch(i % 2, i, a, to, mv);
      checks++;
      if (to || mv || a !== ea) begin
        errors++; $display("FAIL seq_req_%0d: got addr=%h to=%b moved=%b want %h", i, a, to, mv, ea);
      end
      consume(1'b0, pc, ins, cto);
      e = exp_q.pop_front();
      checks++;
      if (cto || {pc, ins} !== e) begin
        errors++; $display("FAIL seq_out_%0d: got %h/%h to=%b want %h/%h", i, pc, ins, cto, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_branch_taken();
    logic [31:0] a, pc, ins;
    logic [63:0] e;
    bit to, mv, cto;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({32'hBFC0_0010 + 32'(i * 4), mem(32'hBFC0_0010 + 32'(i * 4))});
      bus_fetch(0, 0, a, to, mv);
      checks++;
      if (to || a !== 32'hBFC0_0010 + 32'(i * 4)) begin
        errors++; $display("FAIL br_req_%0d: got %h to=%b want %h", i, a, to, 32'hBFC0_0010 + 32'(i * 4));
      end
      consume(i == 0, pc, ins, cto);
      e = exp_q.pop_front();
      checks++;
      if (cto || {pc, ins} !== e) begin
        errors++; $display("FAIL br_out_%0d: got %h/%h want %h/%h", i, pc, ins, e[63:32], e[31:0]);
      end
    end
    checks++;
    if (br_stall !== 1'b1 || ireq_valid !== 1'b0) begin
      errors++; $display("FAIL br_stall_enter: got stall=%b req=%b want 1/0", br_stall, ireq_valid);
    end
    tick();
    tick();
    checks++;
    if (br_stall !== 1'b1 || ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL br_stall_hold: got stall=%b req=%b ov=%b want 1/0/0", br_stall, ireq_valid, out_valid);
    end
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'hBFC0_0100;
    tick();
    res_valid = 1'b0; res_taken = 1'b0;
    checks++;
    if (br_stall !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0100) begin
      errors++; $display("FAIL br_taken_target: got stall=%b req=%b addr=%h want 0/1/bfc00100", br_stall, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_branch_not_taken_early();
    logic [31:0] a, pc, ins;
    logic [63:0] e;
    bit to, mv, cto;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'hBFC0_0100 + 32'(i * 4), mem(32'hBFC0_0100 + 32'(i * 4))});
      bus_fetch(1, 0, a, to, mv);
      checks++;
      if (to || a !== 32'hBFC0_0100 + 32'(i * 4)) begin
        errors++; $display("FAIL nt_req_%0d: got %h to=%b want %h", i, a, to, 32'hBFC0_0100 + 32'(i * 4));
      end
      consume(i == 1, pc, ins, cto);
      e = exp_q.pop_front();
      checks++;
      if (cto || {pc, ins} !== e) begin
        errors++; $display("FAIL nt_out_%0d: got %h/%h want %h/%h", i, pc, ins, e[63:32], e[31:0]);
      end
      if (i == 1) begin
        res_valid = 1'b1; res_taken = 1'b0; res_target = 32'hBFC0_0500;
        tick();
        res_valid = 1'b0;
      end
    end
    checks++;
    if (br_stall !== 1'b1 || ireq_valid !== 1'b0) begin
      errors++; $display("FAIL nt_bubble: got stall=%b req=%b want 1/0", br_stall, ireq_valid);
    end
    tick();
    checks++;
    if (br_stall !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_010C) begin
      errors++; $display("FAIL nt_resume: got stall=%b req=%b addr=%h want 0/1/bfc0010c", br_stall, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_flush_wait();
    logic [31:0] a, pc, ins;
    logic [63:0] e;
    bit to, mv, cto;
    ireq_addr_ok = 1'b1;
    tick();
    ireq_addr_ok = 1'b0;
    flush = 1'b1; flush_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0;
    checks++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_wait_hold: got req=%b ov=%b want 0/0", ireq_valid, out_valid);
    end
    tick();
    iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_data_ok = 1'b0; iresp_data = '0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0380) begin
      errors++; $display("FAIL flush_drop: got ov=%b req=%b addr=%h want 0/1/bfc00380", out_valid, ireq_valid, ireq_addr);
    end
    exp_q.push_back({32'hBFC0_0380, mem(32'hBFC0_0380)});
    bus_fetch(0, 1, a, to, mv);
    consume(1'b0, pc, ins, cto);
    e = exp_q.pop_front();
    checks++;
    if (to || cto || {pc, ins} !== e) begin
      errors++; $display("FAIL flush_first_out: got %h/%h want %h/%h", pc, ins, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_hold_backpressure();
    logic [31:0] a, pc, ins;
    logic [63:0] e;
    bit to, mv, cto;
    exp_q.push_back({32'hBFC0_0384, mem(32'hBFC0_0384)});
    bus_fetch(0, 0, a, to, mv);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC0_0384 || out_instr !== mem(32'hBFC0_0384) || ireq_valid !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got ov=%b pc=%h instr=%h req=%b want 1/bfc00384/%h/0", i, out_valid, out_pc, out_instr, ireq_valid, mem(32'hBFC0_0384));
      end
      tick();
    end
    consume(1'b0, pc, ins, cto);
    e = exp_q.pop_front();
    checks++;
    if (to || cto || {pc, ins} !== e) begin
      errors++; $display("FAIL hold_out: got %h/%h want %h/%h", pc, ins, e[63:32], e[31:0]);
    end
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0388) begin
      errors++; $display("FAIL hold_next: got req=%b addr=%h want 1/bfc00388", ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_flush_wrap();
    logic [31:0] a, pc, ins;
    logic [63:0] e;
    bit to, mv, cto;
    bus_fetch(0, 0, a, to, mv);
    flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL flush_hold_align: got ov=%b req=%b addr=%h want 0/1/fffffffc", out_valid, ireq_valid, ireq_addr);
    end
    exp_q.push_back({32'hFFFF_FFFC, mem(32'hFFFF_FFFC)});
    bus_fetch(0, 0, a, to, mv);
    consume(1'b0, pc, ins, cto);
    e = exp_q.pop_front();
    checks++;
    if (to || cto || {pc, ins} !== e) begin
      errors++; $display("FAIL wrap_out: got %h/%h want %h/%h", pc, ins, e[63:32], e[31:0]);
    end
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got req=%b addr=%h want 1/00000000", ireq_valid, ireq_addr);
    end
    ireq_addr_ok = 1'b1; flush = 1'b1; flush_pc = 32'hBFC0_0200;
    tick();
    ireq_addr_ok = 1'b0; flush = 1'b0;
    checks++;
    if (ireq_valid !== 1'b0) begin errors++; $display("FAIL flush_addr_ok_wait: got req=%b want 0", ireq_valid); end
    iresp_data_ok = 1'b1; iresp_data = 32'hFEED_0000;
    tick();
    iresp_data_ok = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0200) begin
      errors++; $display("FAIL flush_addr_ok_drop: got ov=%b req=%b addr=%h want 0/1/bfc00200", out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, pc, ins;
    logic [63:0] e;
    bit to, mv, cto;
    ireq_addr_ok = 1'b1;
    tick();
    ireq_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0 || br_stall !== 1'b0) begin
      errors++; $display("FAIL mid_reset_cycle: got req=%b ov=%b stall=%b want 0/0/0", ireq_valid, out_valid, br_stall);
    end
    reset = 1'b0;
    iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_0BAD;
    tick();
    iresp_data_ok = 1'b0; iresp_data = '0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin
      errors++; $display("FAIL mid_reset_stray: got ov=%b req=%b addr=%h want 0/1/%h", out_valid, ireq_valid, ireq_addr, RESET_PC);
    end
    exp_q.push_back({RESET_PC, 32'h2402_0001});
    bus_fetch(0, 0, a, to, mv);
    consume(1'b0, pc, ins, cto);
    e = exp_q.pop_front();
    checks++;
    if (to || cto || {pc, ins} !== e) begin
      errors++; $display("FAIL mid_reset_out: got %h/%h want %h/%h", pc, ins, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch_taken();
    test_branch_not_taken_early();
    test_flush_wait();
    test_hold_backpressure();
    test_flush_wrap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage PC generator and instruction-bus front end for the MIPS pipeline.
- Issues one outstanding fetch at a time, buffers the returned word, and hands {pc, instr} to the jump-select/decode stage.
- Consumes that stage's branch indication plus the later branch resolution from execute, and redirects the PC while honouring the MIPS one-instruction delay slot.
- Also accepts a top-priority exception/ERET flush.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC fetched first after reset
- EXC_HOLD, 1, 1 = drop an in-flight response after flush; 0 = forbidden (reserved)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- ireq_valid  out  1  fetch request valid
- ireq_addr  out  32  fetch address (word aligned)
- ireq_addr_ok  in  1  bus accepted request this cycle
- iresp_data_ok  in  1  response data valid this cycle
- iresp_data  in  32  fetched instruction
- out_valid  out  1  {out_pc, out_instr} valid toward select stage
- out_pc  out  32  PC of delivered instruction
- out_instr  out  32  delivered instruction
- out_ready  in  1  select stage consumes when out_valid & out_ready
- br_is_jmp  in  1  select stage's jmp.valid for the instruction consumed this cycle (sampled only on consume)
- res_valid  in  1  branch resolution from execute
- res_taken  in  1  jmp.en for the resolved branch
- res_target  in  32  jmp.pc_dst for the resolved branch
- flush  in  1  exception/ERET redirect
- flush_pc  in  32  redirect target
- br_stall  out  1  high while in WAIT_RES (fetch frozen awaiting resolution)

Behaviour:
- Reset (synchronous, active-high): pc = RESET_PC; fetch FSM = REQ; branch FSM = NORMAL; drop flag = 0; out_valid = 0; out_pc/out_instr = 0; ireq_valid = 0 in the reset cycle, then 1 in the next cycle with ireq_addr = RESET_PC. Reset mid-operation discards everything, including an outstanding request and its later data_ok.
- Fetch FSM:
  - REQ: ireq_valid = 1, ireq_addr = pc. On ireq_addr_ok -> WAIT.
  - WAIT: ireq_valid = 0. On iresp_data_ok: if drop, clear drop and go to REQ (data discarded); else latch data into the output buffer, set out_valid, and go to HOLD.
  - HOLD: out_valid = 1. On consume: clear out_valid; pc_next per the branch FSM; go to REQ, or to STALL if entering WAIT_RES.
  - STALL: no request; leave when resolution is applied.
- Data_ok may arrive the cycle after addr_ok at the earliest, so minimum PC-to-out_valid latency is 2 cycles after the request is accepted.
- Branch FSM, advanced on each consume:
  - NORMAL, br_is_jmp = 0: pc_next = out_pc + 4.
  - NORMAL, br_is_jmp = 1: -> DSLOT; pc_next = out_pc + 4 (this fetches the delay slot).
  - DSLOT, on consume of the delay slot: -> WAIT_RES; fetch FSM -> STALL.
  - res_valid in any state: latch {taken, target} into resolution regs (one entry; a second res_valid before use overwrites it).
  - WAIT_RES with a resolution latched (same cycle allowed): pc = taken ? target : delay-slot pc + 4; -> NORMAL; fetch FSM -> REQ next cycle.
- Flush (highest priority, any state): pc = flush_pc; out_valid = 0; branch FSM = NORMAL; resolution regs cleared.
  - Fetch FSM in WAIT (and not data_ok this cycle): set drop, stay WAIT.
  - Otherwise: -> REQ.
  - Flush concurrent with data_ok: data discarded, -> REQ.
  - Flush concurrent with addr_ok in REQ: the request counts as issued; set drop, -> WAIT.
- ireq_addr is stable while ireq_valid = 1 and addr_ok = 0, except on flush, which may change it.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. Low two bits of every generated PC are forced to 0.
- br_stall = (branch FSM == WAIT_RES).

Test Plan:
- Reset, then addr_ok in cycle 1 and data_ok in cycle 2 with data 32'h2402_0001 -> out_valid in cycle 3 with out_pc = BFC00000; ready held high -> next ireq_addr = BFC00004.
- Branch at BFC00010 consumed with br_is_jmp = 1 -> delay slot fetched at BFC00014; then br_stall = 1 with no request; res_valid, taken = 1, target = BFC00100 -> next ireq_addr = BFC00100.
- Same sequence with taken = 0 -> next ireq_addr = BFC00018; resolution arriving early (during DSLOT) -> no stall bubble beyond one cycle.
- Flush while in WAIT, flush_pc = BFC00380 -> late data_ok data is never presented; next request address = BFC00380.
- out_ready low for 5 cycles in HOLD -> out_pc/out_instr held stable, no new request issued.
- Reset asserted during WAIT, stray data_ok the cycle after -> ignored; first delivered out_pc = BFC00000.
